// File: rtl/rom_load_sequencer.sv
// Routes hps_io ioctl download bytes into four loadable ROM regions and
// sequences the game core reset around downloads and user reset requests.
module rom_load_sequencer #(
  parameter int unsigned R0_BASE     = 32'h0000,
  parameter int unsigned R0_SIZE     = 32'h2000,
  parameter int unsigned R1_BASE     = 32'h2000,
  parameter int unsigned R1_SIZE     = 32'h0800,
  parameter int unsigned R2_BASE     = 32'h2800,
  parameter int unsigned R2_SIZE     = 32'h1000,
  parameter int unsigned R3_BASE     = 32'h3800,
  parameter int unsigned R3_SIZE     = 32'h0100,
  parameter int unsigned TOTAL_BYTES = 32'h3900,
  parameter int unsigned RESET_HOLD  = 16
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        ioctl_download_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        reset_req_i,
  output logic [3:0]  rom_we_o,
  output logic [12:0] rom_addr_o,
  output logic [7:0]  rom_data_o,
  output logic        core_reset_o,
  output logic        load_done_o,
  output logic        load_error_o
);

  localparam int unsigned AW        = 25;
  localparam int unsigned RAW       = 13;
  localparam int unsigned DW        = 8;
  localparam int unsigned CW        = 16;
  localparam int unsigned HW        = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_HOLD, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [3:0]      rom_we_q, rom_we_d;
  logic [RAW-1:0]  rom_addr_q, rom_addr_d;
  logic [DW-1:0]   rom_data_q, rom_data_d;
  logic            core_reset_q, core_reset_d;
  logic            load_done_q, load_done_d;
  logic            load_error_q, load_error_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_base;
  logic [HW-1:0]   hold_q, hold_d;
  logic            oor_q, oor_d;
  logic            block_q, block_d;
  logic            accept_c, start_c;
  logic [3:0]      hit_c, sel_c;
  logic [RAW-1:0]  off_c;

  // Full-width unsigned range test: base <= a < base + size
  function automatic logic in_region(input logic [AW-1:0] a,
                                     input int unsigned base,
                                     input int unsigned size);
    logic [AW:0] diff;
    diff = {1'b0, a} - {1'b0, AW'(base)};
    return !diff[AW] && (diff[AW-1:0] < AW'(size));
  endfunction

  function automatic logic [RAW-1:0] local_addr(input logic [AW-1:0] a,
                                                input int unsigned base);
    logic [AW-1:0] diff;
    diff = a - AW'(base);
    return diff[RAW-1:0];
  endfunction

  // Region decode; the lowest-numbered hit wins if parameters overlap
  always_comb begin
    hit_c[0] = in_region(ioctl_addr_i, R0_BASE, R0_SIZE);
    hit_c[1] = in_region(ioctl_addr_i, R1_BASE, R1_SIZE);
    hit_c[2] = in_region(ioctl_addr_i, R2_BASE, R2_SIZE);
    hit_c[3] = in_region(ioctl_addr_i, R3_BASE, R3_SIZE);
    sel_c    = 4'b0000;
    off_c    = '0;
    if (hit_c[0]) begin
      sel_c = 4'b0001;
      off_c = local_addr(ioctl_addr_i, R0_BASE);
    end else if (hit_c[1]) begin
      sel_c = 4'b0010;
      off_c = local_addr(ioctl_addr_i, R1_BASE);
    end else if (hit_c[2]) begin
      sel_c = 4'b0100;
      off_c = local_addr(ioctl_addr_i, R2_BASE);
    end else if (hit_c[3]) begin
      sel_c = 4'b1000;
      off_c = local_addr(ioctl_addr_i, R3_BASE);
    end
  end

  // Bytes stay blocked after a mid-download reset until download is seen low
  assign accept_c = ioctl_wr_i & ioctl_download_i & ~block_q;
  assign start_c  = ioctl_download_i & ~block_q & (state_q != S_LOAD);

  always_comb begin
    state_d      = state_q;
    rom_we_d     = 4'b0000;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    hold_d       = hold_q;
    block_d      = ioctl_download_i ? block_q : 1'b0;

    if (accept_c && (sel_c != 4'b0000)) begin
      rom_we_d   = sel_c;
      rom_addr_d = off_c;
      rom_data_d = ioctl_dout_i;
    end

    cnt_base = start_c ? '0 : cnt_q;
    cnt_d    = (accept_c && (cnt_base != {CW{1'b1}})) ? cnt_base + CW'(1) : cnt_base;
    oor_d    = (start_c ? 1'b0 : oor_q) | (accept_c & (sel_c == 4'b0000));

    if (start_c) begin
      state_d      = S_LOAD;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (!ioctl_download_i) begin
            state_d      = S_HOLD;
            hold_d       = HOLD_INIT;
            load_done_d  = 1'b1;
            load_error_d = (cnt_d != CW'(TOTAL_BYTES)) | oor_d;
          end
        end
        S_HOLD: begin
          if (reset_req_i)          hold_d = HOLD_INIT;
          else if (hold_q == '0)    state_d = S_RUN;
          else                      hold_d = hold_q - HW'(1);
        end
        S_RUN: begin
          if (reset_req_i) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        default: ;
      endcase
    end

    core_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q      <= S_WAIT;
      rom_we_q     <= 4'b0000;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      oor_q        <= 1'b0;
      block_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      oor_q        <= oor_d;
      block_q      <= block_d;
    end
  end

  assign rom_we_o     = rom_we_q;
  assign rom_addr_o   = rom_addr_q;
  assign rom_data_o   = rom_data_q;
  assign core_reset_o = core_reset_q;
  assign load_done_o  = load_done_q;
  assign load_error_o = load_error_q;

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download interface and the Ultra Tank core's loadable ROM/PROM regions.
- Decodes each download byte into one of four regions and issues a one-hot write strobe with a region-local address.
- Holds the core in reset during a download and for a fixed number of cycles afterwards.
- Flags incomplete or out-of-range loads.
- Also sequences user reset requests (menu reset or OSD button) through the same reset-hold path.

Parameters:
- R0_BASE, 0x0000, program ROM base in ioctl address space
- R0_SIZE, 0x2000, program ROM size in bytes
- R1_BASE, 0x2000, playfield/char ROM base
- R1_SIZE, 0x0800, char ROM size
- R2_BASE, 0x2800, motion-object ROM base
- R2_SIZE, 0x1000, object ROM size
- R3_BASE, 0x3800, sync/colour PROM base
- R3_SIZE, 0x0100, PROM size
- TOTAL_BYTES, 0x3900, byte count expected for a complete load
- RESET_HOLD, 16, clk_sys cycles core_reset stays high after a load or reset request

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  byte-valid strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- reset_req  in  1  user reset request (level)
- rom_we  out  4  one-hot region write strobe; bit n = region n
- rom_addr  out  13  region-local address (ioctl_addr - Rn_BASE)
- rom_data  out  8  write data
- core_reset  out  1  active-high reset to the game core
- load_done  out  1  a download has completed since the last reset
- load_error  out  1  last download was short or long, or had out-of-range writes

Behaviour:
- Reset values:
  - state = WAIT; core_reset = 1; load_done = 0; load_error = 0.
  - rom_we = 0; rom_addr = 0; rom_data = 0; byte counter = 0; hold counter = 0; oor flag = 0.
- States: WAIT, LOAD, HOLD, RUN.
- WAIT:
  - core_reset = 1.
  - ioctl_download = 1 → LOAD.
  - Core never runs before the first completed download.
- LOAD:
  - core_reset = 1.
  - On entry (first cycle with ioctl_download = 1), clear byte counter, oor flag, load_done and load_error.
  - ioctl_download = 0 → HOLD, hold counter loaded with RESET_HOLD - 1.
- HOLD:
  - core_reset = 1. Hold counter decrements every cycle.
  - At 0 → RUN.
  - ioctl_download = 1 → LOAD (abort hold).
  - reset_req = 1 reloads the hold counter.
- RUN:
  - core_reset = 0.
  - ioctl_download = 1 → LOAD.
  - reset_req = 1 → HOLD with the counter reloaded; load_done and load_error are unchanged.
- Byte acceptance:
  - A byte is accepted in any cycle with ioctl_wr = 1 and ioctl_download = 1, independent of the registered state. This covers the first-cycle and last-cycle edge cases.
  - ioctl_wr with ioctl_download = 0 is ignored.
- Decode (registered, 1-cycle latency):
  - Region n hits when Rn_BASE ≤ ioctl_addr < Rn_BASE + Rn_SIZE. Compare on the full 25 bits.
  - Cycle after acceptance: rom_we[n] = 1 for exactly one cycle; rom_addr = (ioctl_addr - Rn_BASE)[12:0]; rom_data = ioctl_dout.
  - rom_addr and rom_data hold their last value otherwise.
  - Regions do not overlap; if the parameters overlap, the lowest n wins.
  - An accepted byte that hits no region produces no strobe and sets the oor flag.
- Byte counter:
  - 16 bits, increments on every accepted byte (including out-of-range bytes).
  - Saturates at 0xFFFF.
- On the LOAD → HOLD transition:
  - load_done ← 1.
  - load_error ← (byte counter ≠ TOTAL_BYTES) | oor flag, evaluated after any byte accepted in that same cycle.
- reset_req in WAIT or LOAD has no effect.
- Synchronous reset mid-LOAD:
  - Returns to WAIT immediately; core_reset = 1.
  - Any pending rom_we strobe is squashed in that cycle.
  - Remaining download bytes are ignored until ioctl_download deasserts and reasserts.
  - ioctl_download must be seen at 0 at least one cycle before WAIT re-enters LOAD.

Test Plan:
- Reset, then full 0x3900-byte download with consecutive ioctl_wr, address = index, data = index[7:0]:
  - Addr 0x2000 gives rom_we = 0010, rom_addr = 0x000; addr 0x38FF gives rom_we = 1000, rom_addr = 0x0FF, one cycle after each strobe.
  - After download falls: core_reset = 1 for exactly 16 cycles, then 0; load_done = 1; load_error = 0.
- Short download of 0x3000 bytes:
  - load_done = 1, load_error = 1.
  - Bytes ≥ 0x3000 are never strobed.
- Download containing a write to 0x3A00:
  - No rom_we for that byte; load_error = 1 even though the count equals 0x3900 (one region byte omitted).
- In RUN, pulse reset_req for 1 cycle:
  - core_reset high for 16 cycles; load_done stays 1; no rom_we activity.
- Assert reset after 100 bytes of a download:
  - Next cycle: state WAIT, rom_we = 0, core_reset = 1; subsequent bytes produce no strobes.
  - After ioctl_download toggles 0 → 1, a fresh full load completes with load_error = 0.
- New download started 5 cycles into HOLD:
  - Returns to LOAD, counter and flags cleared; core_reset never drops between the two loads.
